// File: rtl/aclk_pkg.sv
// Shared alarm-clock definitions: entry FSM states, BCD digit type and the
// 24-hour HH:MM digit limits used by the key entry, counter and alarm blocks.
package aclk_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ENTRY = 1'b1
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_MS_HR      = 4'd2;
  localparam bcd_t MAX_LS_HR_AT_2 = 4'd3;
  localparam bcd_t MAX_MS_MIN     = 4'd5;
  localparam bcd_t MAX_DIGIT      = 4'd9;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= MAX_DIGIT;
  endfunction

endpackage

// File: rtl/aclk_time_validate.sv
// Combinational 24-hour HH:MM check on four BCD digits; shared by any block
// that must accept or reject a keyed-in time.
module aclk_time_validate
  import aclk_pkg::*;
(
  input  bcd_t i_ms_hr,
  input  bcd_t i_ls_hr,
  input  bcd_t i_ms_min,
  input  bcd_t i_ls_min,
  output logic o_valid
);

  logic w_digits_ok;
  logic w_hours_ok;
  logic w_mins_ok;

  always_comb begin
    w_digits_ok = is_digit(i_ms_hr) && is_digit(i_ls_hr) &&
                  is_digit(i_ms_min) && is_digit(i_ls_min);
    // Hours 20-23 need the units digit capped; 00-19 only need the tens cap.
    w_hours_ok  = (i_ms_hr < MAX_MS_HR) ||
                  ((i_ms_hr == MAX_MS_HR) && (i_ls_hr <= MAX_LS_HR_AT_2));
    w_mins_ok   = (i_ms_min <= MAX_MS_MIN);
    o_valid     = w_digits_ok && w_hours_ok && w_mins_ok;
  end

endmodule

// File: rtl/aclk_key_entry.sv
// Alarm-clock key entry: shifts BCD key strokes into an HH:MM buffer and
// commits it to the time counter or alarm register. Macro ACLK_KEY_TIMEOUT_EN
// enables the idle timeout that discards abandoned entries.
module aclk_key_entry
  import aclk_pkg::*;
#(
  parameter int unsigned TIMEOUT_SEC = 10,
  parameter int unsigned TMR_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_second,
  input  logic       key_valid,
  input  logic [3:0] key,
  input  logic       load_time_btn,
  input  logic       load_alarm_btn,
  output logic [3:0] new_current_ms_hr,
  output logic [3:0] new_current_ls_hr,
  output logic [3:0] new_current_ms_min,
  output logic [3:0] new_current_ls_min,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       entry_active,
  output logic       entry_error
);

`ifdef ACLK_KEY_TIMEOUT_EN
  localparam bit TMR_EN = 1'b1;
`else
  localparam bit TMR_EN = 1'b0;
`endif

  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_SEC);

  state_t           r_state,  w_state_nx;
  bcd_t             r_ms_hr,  w_ms_hr_nx;
  bcd_t             r_ls_hr,  w_ls_hr_nx;
  bcd_t             r_ms_min, w_ms_min_nx;
  bcd_t             r_ls_min, w_ls_min_nx;
  logic             r_load_c, w_load_c_nx;
  logic             r_load_a, w_load_a_nx;
  logic             r_err,    w_err_nx;
  logic [TMR_W-1:0] r_timer,  w_timer_nx;

  logic             w_valid;
  logic             w_btn;
  logic             w_key_dig;
  logic             w_key_bad;
  logic             w_tick;
  logic [TMR_W-1:0] w_timer_inc;

  aclk_time_validate u_validate (
    .i_ms_hr  (r_ms_hr),
    .i_ls_hr  (r_ls_hr),
    .i_ms_min (r_ms_min),
    .i_ls_min (r_ls_min),
    .o_valid  (w_valid)
  );

  assign w_btn       = load_time_btn | load_alarm_btn;
  assign w_key_dig   = key_valid & is_digit(key);
  assign w_key_bad   = key_valid & ~is_digit(key);
  // With the timeout compiled out the tick is constant 0 and the timer folds away.
  assign w_tick      = one_second & TMR_EN;
  assign w_timer_inc = r_timer + TMR_W'(1);

  always_comb begin
    w_state_nx  = r_state;
    w_ms_hr_nx  = r_ms_hr;
    w_ls_hr_nx  = r_ls_hr;
    w_ms_min_nx = r_ms_min;
    w_ls_min_nx = r_ls_min;
    w_timer_nx  = r_timer;
    w_load_c_nx = 1'b0;
    w_load_a_nx = 1'b0;
    w_err_nx    = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_key_dig) begin
          w_ms_hr_nx  = '0;
          w_ls_hr_nx  = '0;
          w_ms_min_nx = '0;
          w_ls_min_nx = key;
          w_timer_nx  = '0;
          w_state_nx  = ENTRY;
        end else if (w_key_bad) begin
          w_err_nx = 1'b1;
        end
      end

      ENTRY: begin
        if (w_btn) begin
          // Validation sees the buffer as it stands; a same-cycle key is dropped.
          if (w_valid) begin
            w_load_c_nx = load_time_btn;
            w_load_a_nx = ~load_time_btn;
          end else begin
            w_err_nx    = 1'b1;
            w_ms_hr_nx  = '0;
            w_ls_hr_nx  = '0;
            w_ms_min_nx = '0;
            w_ls_min_nx = '0;
          end
          w_timer_nx = '0;
          w_state_nx = IDLE;
        end else if (key_valid) begin
          w_timer_nx = '0;
          if (w_key_dig) begin
            w_ms_hr_nx  = r_ls_hr;
            w_ls_hr_nx  = r_ms_min;
            w_ms_min_nx = r_ls_min;
            w_ls_min_nx = key;
          end else begin
            w_err_nx = 1'b1;
          end
        end else if (w_tick) begin
          if (w_timer_inc == TMR_LIMIT) begin
            w_ms_hr_nx  = '0;
            w_ls_hr_nx  = '0;
            w_ms_min_nx = '0;
            w_ls_min_nx = '0;
            w_timer_nx  = '0;
            w_state_nx  = IDLE;
          end else begin
            w_timer_nx = w_timer_inc;
          end
        end
      end

      default: w_state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_ms_hr  <= '0;
      r_ls_hr  <= '0;
      r_ms_min <= '0;
      r_ls_min <= '0;
      r_load_c <= 1'b0;
      r_load_a <= 1'b0;
      r_err    <= 1'b0;
      r_timer  <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_ms_hr  <= w_ms_hr_nx;
      r_ls_hr  <= w_ls_hr_nx;
      r_ms_min <= w_ms_min_nx;
      r_ls_min <= w_ls_min_nx;
      r_load_c <= w_load_c_nx;
      r_load_a <= w_load_a_nx;
      r_err    <= w_err_nx;
      r_timer  <= w_timer_nx;
    end
  end

  assign new_current_ms_hr  = r_ms_hr;
  assign new_current_ls_hr  = r_ls_hr;
  assign new_current_ms_min = r_ms_min;
  assign new_current_ls_min = r_ls_min;
  assign load_new_c         = r_load_c;
  assign load_new_a         = r_load_a;
  assign entry_active       = (r_state == ENTRY);
  assign entry_error        = r_err;

endmodule

// File: tb/tb_aclk_key_entry.sv
// Self-checking bench for aclk_key_entry: directed scenarios with literal
// expectations plus randomized traffic against a decimal-arithmetic model.
module tb_aclk_key_entry;

  localparam int TO = 3;
`ifdef ACLK_KEY_TIMEOUT_EN
  localparam bit TMO = 1'b1;
`else
  localparam bit TMO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       one_second = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key = 4'd0;
  logic       load_time_btn = 1'b0;
  logic       load_alarm_btn = 1'b0;
  logic [3:0] ms_hr, ls_hr, ms_min, ls_min;
  logic       load_new_c, load_new_a, entry_active, entry_error;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  aclk_key_entry #(.TIMEOUT_SEC(TO), .TMR_W(8)) dut (
    .clk                (clk),
    .reset              (reset),
    .one_second         (one_second),
    .key_valid          (key_valid),
    .key                (key),
    .load_time_btn      (load_time_btn),
    .load_alarm_btn     (load_alarm_btn),
    .new_current_ms_hr  (ms_hr),
    .new_current_ls_hr  (ls_hr),
    .new_current_ms_min (ms_min),
    .new_current_ls_min (ls_min),
    .load_new_c         (load_new_c),
    .load_new_a         (load_new_a),
    .entry_active       (entry_active),
    .entry_error        (entry_error)
  );

  // Reference: buffer held as a decimal number HHMM, entry open as a flag.
  int m_buf = 0;
  bit m_open = 1'b0;
  int m_tmr = 0;
  bit m_c = 1'b0, m_a = 1'b0, m_e = 1'b0;

  always @(posedge clk) begin : ref_model
    int b, t;
    bit o, c, a, e;
    b = m_buf; t = m_tmr; o = m_open; c = 1'b0; a = 1'b0; e = 1'b0;
    if (reset) begin
      b = 0; t = 0; o = 1'b0;
    end else if (!o) begin
      if (key_valid) begin
        if (key < 4'd10) begin b = int'(key); o = 1'b1; t = 0; end
        else e = 1'b1;
      end
    end else if (load_time_btn || load_alarm_btn) begin
      if ((b / 100) < 24 && (b % 100) < 60) begin
        c = load_time_btn; a = !load_time_btn;
      end else begin
        e = 1'b1; b = 0;
      end
      o = 1'b0; t = 0;
    end else if (key_valid) begin
      t = 0;
      if (key < 4'd10) b = (b * 10 + int'(key)) % 10000;
      else e = 1'b1;
    end else if (TMO && one_second) begin
      t = t + 1;
      if (t == TO) begin b = 0; o = 1'b0; t = 0; end
    end
    m_buf <= b; m_tmr <= t; m_open <= o; m_c <= c; m_a <= a; m_e <= e;
  end

  always @(negedge clk) begin : compare
    logic [19:0] got, exp;
    got = {ms_hr, ls_hr, ms_min, ls_min, load_new_c, load_new_a, entry_active, entry_error};
    exp = {4'(m_buf / 1000), 4'((m_buf / 100) % 10), 4'((m_buf / 10) % 10), 4'(m_buf % 10),
           m_c, m_a, m_open, m_e};
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL model_cmp t=%0t got digits=%h c=%b a=%b act=%b err=%b exp digits=%h c=%b a=%b act=%b err=%b",
               $time, got[19:4], got[3], got[2], got[1], got[0],
               exp[19:4], exp[3], exp[2], exp[1], exp[0]);
    end
  end

  function automatic int dig_val();
    return int'(ms_hr) * 1000 + int'(ls_hr) * 100 + int'(ms_min) * 10 + int'(ls_min);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic apply(input bit rst, input bit kv, input logic [3:0] k,
                       input bit lt, input bit la, input bit os);
    reset = rst; key_valid = kv; key = k;
    load_time_btn = lt; load_alarm_btn = la; one_second = os;
    @(posedge clk);
    #1;
    reset = 1'b0; key_valid = 1'b0; key = 4'd0;
    load_time_btn = 1'b0; load_alarm_btn = 1'b0; one_second = 1'b0;
  endtask

  task automatic press(input logic [3:0] k);
    apply(1'b0, 1'b1, k, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic nop();
    apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_digits", dig_val(), 0);
    chk("reset_active", int'(entry_active), 0);
    chk("reset_strobes", int'({load_new_c, load_new_a, entry_error}), 0);

    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("t1_active", int'(entry_active), 1);
    apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("t1_digits", dig_val(), 1234);
    chk("t1_load_c", int'(load_new_c), 1);
    chk("t1_load_a", int'(load_new_a), 0);
    chk("t1_active_fall", int'(entry_active), 0);
    nop();
    chk("t1_load_c_one_cycle", int'(load_new_c), 0);
    chk("t1_digits_hold", dig_val(), 1234);

    press(4'd2); press(4'd4); press(4'd0); press(4'd0);
    apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("t2_err", int'(entry_error), 1);
    chk("t2_no_strobe", int'({load_new_c, load_new_a}), 0);
    chk("t2_cleared", dig_val(), 0);
    chk("t2_idle", int'(entry_active), 0);
    press(4'd2); press(4'd3); press(4'd5); press(4'd9);
    apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("t2_load_a", int'(load_new_a), 1);
    chk("t2_load_c", int'(load_new_c), 0);
    chk("t2_digits", dig_val(), 2359);

    press(4'd9); press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    chk("t3_shift_drop", dig_val(), 1234);
    press(4'd12);
    chk("t3_bad_key_err", int'(entry_error), 1);
    chk("t3_bad_key_buf", dig_val(), 1234);
    chk("t3_bad_key_open", int'(entry_active), 1);
    nop();
    chk("t3_err_one_cycle", int'(entry_error), 0);
    apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);

`ifdef ACLK_KEY_TIMEOUT_EN
    press(4'd5); tick(); nop(); tick();
    chk("t4_open_after_two", int'(entry_active), 1);
    tick();
    chk("t4_timeout_idle", int'(entry_active), 0);
    chk("t4_timeout_buf", dig_val(), 0);
    chk("t4_timeout_quiet", int'({load_new_c, load_new_a, entry_error}), 0);
    press(4'd5); tick(); tick(); press(4'd6); tick(); tick();
    chk("t4_restart_open", int'(entry_active), 1);
    chk("t4_restart_buf", dig_val(), 56);
    tick();
    chk("t4_restart_expire", int'(entry_active), 0);
    chk("t4_restart_buf_clr", dig_val(), 0);
`else
    press(4'd5);
    repeat (300) tick();
    chk("t4_no_timeout_open", int'(entry_active), 1);
    chk("t4_no_timeout_buf", dig_val(), 5);
    apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
`endif

    press(4'd0); press(4'd8); press(4'd1); press(4'd5);
    apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0);
    chk("t5_both_c", int'(load_new_c), 1);
    chk("t5_both_a", int'(load_new_a), 0);
    nop();
    apply(1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("t5_idle_btn_c", int'(load_new_c), 0);
    chk("t5_idle_btn_err", int'(entry_error), 0);
    chk("t5_idle_btn_buf", dig_val(), 815);
    apply(1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    chk("t5_idle_btn_a", int'(load_new_a), 0);

    press(4'd7);
    apply(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("t6_reset_buf", dig_val(), 0);
    chk("t6_reset_flags", int'({load_new_c, load_new_a, entry_active, entry_error}), 0);

    for (int i = 0; i < 4000; i++) begin
      bit kv, lt, la, os, rst;
      logic [3:0] k;
      kv  = ($urandom_range(0, 99) < 30);
      k   = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      lt  = ($urandom_range(0, 99) < 4);
      la  = ($urandom_range(0, 99) < 4);
      os  = ($urandom_range(0, 99) < 25);
      rst = ($urandom_range(0, 499) == 0);
      apply(rst, kv, k, lt, la, os);
    end
    nop();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
